// File: rtl/vshift_lane_issuer.sv
// Vector shift lane issuer: splits a vector shift instruction into groups of
// LANES elements, drives the rotating serial shifter lanes, waits for every
// lane to finish, then masks the rotated results into true SLL/SRL/SRA values
// and presents each group on a valid/ready writeback port.
module vshift_lane_issuer #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int VLBITS = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VLBITS-1:0]      in_vl,
    input  logic [1:0]             in_op,
    input  logic                   elm_valid,
    output logic                   elm_ready,
    input  logic [LANES*WIDTH-1:0] elm_opb,
    input  logic [LANES*5-1:0]     elm_sa,
    output logic                   sh_start,
    output logic [LANES*WIDTH-1:0] sh_opb,
    output logic [LANES*5-1:0]     sh_sa,
    output logic [1:0]             sh_op,
    input  logic [LANES-1:0]       sh_stalled,
    input  logic [LANES*WIDTH-1:0] sh_result,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [LANES*WIDTH-1:0] wb_data,
    output logic [LANES-1:0]       wb_mask,
    output logic                   wb_last,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    localparam logic [VLBITS-1:0] LANES_V = VLBITS'(LANES);

    state_t                 state_q, state_d;
    logic [VLBITS-1:0]      remaining_q, remaining_d;
    logic [1:0]             op_q, op_d;
    logic [LANES*WIDTH-1:0] sh_opb_q, sh_opb_d;
    logic [LANES*5-1:0]     sh_sa_q, sh_sa_d;
    logic [LANES-1:0]       sign_q, sign_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic [LANES*WIDTH-1:0] wb_data_q, wb_data_d;
    logic [LANES*WIDTH-1:0] fixed_res;

    // Per-lane fix-up: the lanes only rotate, so clear the wrapped-in bits and
    // fill with the sign for SRA. Inactive lanes always read back as zero.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_fix
            logic [4:0]       s;
            logic [WIDTH-1:0] res;
            logic [WIDTH-1:0] lmask;
            logic [WIDTH-1:0] rmask;
            logic [WIDTH-1:0] rfix;
            assign s     = sh_sa_q[gi*5 +: 5];
            assign res   = sh_result[gi*WIDTH +: WIDTH];
            assign lmask = {WIDTH{1'b1}} << s;
            assign rmask = {WIDTH{1'b1}} >> s;
            assign rfix  = (res & rmask) | ((op_q[1] && sign_q[gi]) ? ~rmask : '0);
            assign fixed_res[gi*WIDTH +: WIDTH] =
                !mask_q[gi] ? '0 : (op_q[0] ? rfix : (res & lmask));
        end
    endgenerate

    // Next-state logic: instruction accept, group fetch, issue, wait, writeback.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        sh_opb_d    = sh_opb_q;
        sh_sa_d     = sh_sa_q;
        sign_d      = sign_q;
        mask_d      = mask_q;
        wb_data_d   = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    remaining_d = in_vl;
                    op_d        = in_op;
                    if (in_vl != '0) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (elm_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (VLBITS'(i) < remaining_q) begin
                            sh_opb_d[i*WIDTH +: WIDTH] = elm_opb[i*WIDTH +: WIDTH];
                            sh_sa_d[i*5 +: 5]          = elm_sa[i*5 +: 5];
                            mask_d[i]                  = 1'b1;
                            sign_d[i]                  = elm_opb[i*WIDTH + WIDTH - 1];
                        end else begin
                            sh_opb_d[i*WIDTH +: WIDTH] = '0;
                            sh_sa_d[i*5 +: 5]          = '0;
                            mask_d[i]                  = 1'b0;
                            sign_d[i]                  = 1'b0;
                        end
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (~|sh_stalled) begin
                    wb_data_d = fixed_res;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    if (remaining_q <= LANES_V) begin
                        remaining_d = '0;
                        state_d     = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - LANES_V;
                        state_d     = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            op_q        <= '0;
            sh_opb_q    <= '0;
            sh_sa_q     <= '0;
            sign_q      <= '0;
            mask_q      <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            sh_opb_q    <= sh_opb_d;
            sh_sa_q     <= sh_sa_d;
            sign_q      <= sign_d;
            mask_q      <= mask_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign elm_ready = (state_q == S_FETCH);
    assign sh_start  = (state_q == S_ISSUE);
    assign wb_valid  = (state_q == S_WB);
    assign busy      = (state_q != S_IDLE);
    assign wb_last   = (state_q == S_WB) && (remaining_q <= LANES_V);
    assign wb_data   = wb_data_q;
    assign wb_mask   = mask_q;
    assign sh_opb    = sh_opb_q;
    assign sh_sa     = sh_sa_q;
    assign sh_op     = op_q;

endmodule

// File: tb/tb_vshift_lane_issuer.sv
// Directed bench for vshift_lane_issuer with a simple rotating-lane model.
module tb_vshift_lane_issuer;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int VB = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [VB-1:0]    in_vl;
    logic [1:0]       in_op;
    logic             elm_valid;
    logic             elm_ready;
    logic [L*W-1:0]   elm_opb;
    logic [L*5-1:0]   elm_sa;
    logic             sh_start;
    logic [L*W-1:0]   sh_opb;
    logic [L*5-1:0]   sh_sa;
    logic [1:0]       sh_op;
    logic [L-1:0]     sh_stalled;
    logic [L*W-1:0]   sh_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [L*W-1:0]   wb_data;
    logic [L-1:0]     wb_mask;
    logic             wb_last;
    logic             busy;

    vshift_lane_issuer #(.WIDTH(W), .LANES(L), .VLBITS(VB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vl      (in_vl),
        .in_op      (in_op),
        .elm_valid  (elm_valid),
        .elm_ready  (elm_ready),
        .elm_opb    (elm_opb),
        .elm_sa     (elm_sa),
        .sh_start   (sh_start),
        .sh_opb     (sh_opb),
        .sh_sa      (sh_sa),
        .sh_op      (sh_op),
        .sh_stalled (sh_stalled),
        .sh_result  (sh_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_mask    (wb_mask),
        .wb_last    (wb_last),
        .busy       (busy)
    );

    // Serial lane model: load on start, then rotate one bit per cycle.
    logic [W-1:0] lane_res [L];
    logic [4:0]   lane_cnt [L];

    always @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            if (reset) begin
                lane_res[i] <= '0;
                lane_cnt[i] <= '0;
            end else if (sh_start) begin
                lane_res[i] <= sh_opb[i*W +: W];
                lane_cnt[i] <= sh_sa[i*5 +: 5];
            end else if (lane_cnt[i] != 0) begin
                lane_res[i] <= sh_op[0] ? {lane_res[i][0], lane_res[i][W-1:1]}
                                        : {lane_res[i][W-2:0], lane_res[i][W-1]};
                lane_cnt[i] <= lane_cnt[i] - 5'd1;
            end
        end
    end

    always_comb begin
        sh_result  = '0;
        sh_stalled = '0;
        for (int i = 0; i < L; i++) begin
            sh_result[i*W +: W] = lane_res[i];
            sh_stalled[i]       = (lane_cnt[i] != 0);
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]     op;
        logic [VB-1:0]  vl;
        logic [L*W-1:0] opb;
        logic [L*5-1:0] sa;
        logic [L*W-1:0] exp;
        logic [L-1:0]   mask;
        logic           last;
        logic [7:0]     lat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic [VB-1:0] vl, input logic [1:0] op, input string tag);
        chk($sformatf("%s in_ready", tag), {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_vl    = vl;
        in_op    = op;
        tick();
        in_valid = 1'b0;
        in_vl    = '0;
    endtask

    task automatic do_group(input logic [L*W-1:0] opb, input logic [L*5-1:0] sa,
                            input logic [L*W-1:0] exp, input logic [L-1:0] mask,
                            input logic last, input int lat_exp, input int hold,
                            input string tag);
        int n;
        logic [L*W-1:0] mopb;
        n = 0;
        while (!elm_ready && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("%s elm_ready", tag), {127'd0, elm_ready}, 128'd1);
        elm_valid = 1'b1;
        elm_opb   = opb;
        elm_sa    = sa;
        tick();
        elm_valid = 1'b0;
        elm_opb   = '0;
        elm_sa    = '0;
        for (int i = 0; i < L; i++) begin
            mopb[i*W +: W] = mask[i] ? opb[i*W +: W] : '0;
        end
        chk($sformatf("%s sh_start", tag), {127'd0, sh_start}, 128'd1);
        chk($sformatf("%s sh_opb", tag), sh_opb, mopb);
        n = 0;
        while (!wb_valid && n < 80) begin
            tick();
            n++;
        end
        chk($sformatf("%s latency", tag), 128'(n), 128'(lat_exp));
        chk($sformatf("%s wb_data", tag), wb_data, exp);
        chk($sformatf("%s wb_mask/last", tag), {123'd0, wb_mask, wb_last}, {123'd0, mask, last});
        for (int h = 0; h < hold; h++) begin
            tick();
            chk($sformatf("%s hold%0d ctl", tag, h),
                {120'd0, wb_valid, elm_ready, sh_start, wb_mask, wb_last},
                {120'd0, 1'b1, 1'b0, 1'b0, mask, last});
            chk($sformatf("%s hold%0d data", tag, h), wb_data, exp);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk($sformatf("%s wb_valid drop", tag), {127'd0, wb_valid}, 128'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk($sformatf("%s ctl", tag),
            {122'd0, in_ready, elm_ready, sh_start, wb_valid, wb_last, busy},
            {122'd0, 6'b100000});
        chk($sformatf("%s wb_data", tag), wb_data, 128'd0);
        chk($sformatf("%s wb_mask/sh_op", tag), {122'd0, wb_mask, sh_op}, 128'd0);
        chk($sformatf("%s sh_opb", tag), sh_opb, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // op, vl, opb{l3,l2,l1,l0}, sa{l3..l0}, expected{l3..l0}, mask, last, latency
        vecs[0] = '{op: 2'b00, vl: 7'd4, opb: {4{32'h8000_0001}}, sa: {4{5'd1}},
                    exp: {4{32'h0000_0002}}, mask: 4'b1111, last: 1'b1, lat: 8'd3};
        vecs[1] = '{op: 2'b11, vl: 7'd4, opb: {4{32'h8000_0000}}, sa: {4{5'd31}},
                    exp: {4{32'hFFFF_FFFF}}, mask: 4'b1111, last: 1'b1, lat: 8'd33};
        vecs[2] = '{op: 2'b01, vl: 7'd4, opb: {4{32'h8000_0000}}, sa: {4{5'd31}},
                    exp: {4{32'h0000_0001}}, mask: 4'b1111, last: 1'b1, lat: 8'd33};
        vecs[3] = '{op: 2'b00, vl: 7'd4, opb: {4{32'h0000_0001}}, sa: {4{5'd31}},
                    exp: {4{32'h8000_0000}}, mask: 4'b1111, last: 1'b1, lat: 8'd33};
        vecs[4] = '{op: 2'b11, vl: 7'd4, opb: {4{32'hDEAD_BEEF}}, sa: {4{5'd0}},
                    exp: {4{32'hDEAD_BEEF}}, mask: 4'b1111, last: 1'b1, lat: 8'd2};
        vecs[5] = '{op: 2'b11, vl: 7'd3,
                    opb: {32'h1234_5678, 32'h8000_0000, 32'h0000_00F0, 32'hF000_0000},
                    sa:  {5'd9, 5'd0, 5'd4, 5'd4},
                    exp: {32'h0000_0000, 32'h8000_0000, 32'h0000_000F, 32'hFF00_0000},
                    mask: 4'b0111, last: 1'b1, lat: 8'd6};
        vecs[6] = '{op: 2'b10, vl: 7'd4,
                    opb: {32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_00FF},
                    sa:  {5'd2, 5'd16, 5'd4, 5'd8},
                    exp: {32'h3C3C_3C3C, 32'hFFFF_0000, 32'h0000_0010, 32'h0000_FF00},
                    mask: 4'b1111, last: 1'b1, lat: 8'd18};
        vecs[7] = '{op: 2'b01, vl: 7'd4,
                    opb: {32'hF000_0000, 32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFF},
                    sa:  {5'd28, 5'd4, 5'd1, 5'd16},
                    exp: {32'h0000_000F, 32'h0123_4567, 32'h4000_0000, 32'h0000_FFFF},
                    mask: 4'b1111, last: 1'b1, lat: 8'd30};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vl     = '0;
        in_op     = '0;
        elm_valid = 1'b0;
        elm_opb   = '0;
        elm_sa    = '0;
        wb_ready  = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        // Single-group vectors from the table
        for (int v = 0; v < 8; v++) begin
            send_instr(vecs[v].vl, vecs[v].op, $sformatf("vec%0d", v));
            do_group(vecs[v].opb, vecs[v].sa, vecs[v].exp, vecs[v].mask, vecs[v].last,
                     int'(vecs[v].lat), 0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d idle", v), {126'd0, in_ready, busy}, {126'd0, 2'b10});
            $display("vec%0d op=%b vl=%0d wb_data=%h mask=%b", v, vecs[v].op, vecs[v].vl,
                     vecs[v].exp, vecs[v].mask);
        end

        // vl=6: two groups, first held 5 cycles under backpressure
        send_instr(7'd6, 2'b00, "vl6");
        do_group({4{32'h8000_0001}}, {5'd1, 5'd7, 5'd0, 5'd3},
                 {32'h0000_0002, 32'h0000_0080, 32'h8000_0001, 32'h0000_0008},
                 4'b1111, 1'b0, 9, 5, "vl6 g1");
        chk("vl6 g1 next fetch", {126'd0, elm_ready, busy}, {126'd0, 2'b11});
        do_group({4{32'hFFFF_FFFF}}, {5'd9, 5'd9, 5'd5, 5'd2},
                 {32'h0, 32'h0, 32'hFFFF_FFE0, 32'hFFFF_FFFC},
                 4'b0011, 1'b1, 7, 0, "vl6 g2");
        chk("vl6 idle", {126'd0, in_ready, busy}, {126'd0, 2'b10});
        $display("vl6 two groups done");

        // vl=0: accepted, no traffic
        send_instr(7'd0, 2'b00, "vl0");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("vl0 cyc%0d", k),
                {124'd0, in_ready, busy, elm_ready, wb_valid}, {124'd0, 4'b1000});
            tick();
        end
        $display("vl0 done");

        // Reset while waiting on the lanes
        send_instr(7'd4, 2'b01, "rstwait");
        elm_valid = 1'b1;
        elm_opb   = {4{32'hA5A5_A5A5}};
        elm_sa    = {4{5'd20}};
        tick();
        elm_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rstwait in wait", {126'd0, busy, wb_valid}, {126'd0, 2'b10});
        reset = 1'b1;
        tick();
        check_reset_state("rstwait");
        reset = 1'b0;
        send_instr(vecs[0].vl, vecs[0].op, "post-reset");
        do_group(vecs[0].opb, vecs[0].sa, vecs[0].exp, vecs[0].mask, vecs[0].last,
                 int'(vecs[0].lat), 0, "post-reset");
        $display("reset during wait done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
